// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage word access as two 16-bit half-word phases on an async SRAM (optional SRAM_BASE_SUB_EN rebases byte 1024 to SRAM word 0)
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              op_wr, op_wr_nx;
    logic [ADDR_W-2:0] idx, idx_nx;
    logic [31:0]       wd, wd_nx, eff;
    logic              req, start, last, phase_nx, hi_nx, wr_ph_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [15:0]       dq_nx;
    logic              unused;

`ifdef SRAM_BASE_SUB_EN
    assign eff = address - 32'd1024;
`else
    assign eff = address;
`endif

    assign req    = rd_en | wr_en;
    assign start  = state == IDLE && req;
    assign last   = cnt == LAST;
    assign ready  = (state == IDLE && !req) || state == DONE;
    assign unused = ^{eff[31:ADDR_W+1], eff[1:0]};

    // next state and phase counter; the counter restarts on every state change
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                state_nx = req ? LO : IDLE;
                cnt_nx   = 4'd0;
            end
            LO: begin
                state_nx = last ? HI : LO;
                cnt_nx   = last ? 4'd0 : cnt + 4'd1;
            end
            HI: begin
                state_nx = last ? DONE : HI;
                cnt_nx   = last ? 4'd0 : cnt + 4'd1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // operation in effect for the next state, and the SRAM pin values that state wants
    always_comb begin
        op_wr_nx = start ? wr_en : op_wr;
        idx_nx   = start ? eff[ADDR_W:2] : idx;
        wd_nx    = start ? wdata : wd;
        phase_nx = state_nx == LO || state_nx == HI;
        hi_nx    = state_nx == HI;
        wr_ph_nx = phase_nx && op_wr_nx;
        addr_nx  = phase_nx ? {idx_nx, hi_nx} : sram_addr;
        dq_nx    = wr_ph_nx ? (hi_nx ? wd_nx[31:16] : wd_nx[15:0]) : sram_dq_out;
    end

    // state, captured request and registered SRAM pins; we_n releases in the last cycle of a write phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wd          <= 32'd0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            op_wr       <= op_wr_nx;
            idx         <= idx_nx;
            wd          <= wd_nx;
            sram_addr   <= addr_nx;
            sram_dq_out <= dq_nx;
            sram_dq_oe  <= wr_ph_nx;
            sram_we_n   <= !(wr_ph_nx && cnt_nx != LAST);
            sram_oe_n   <= !(phase_nx && !op_wr_nx);
            sram_ce_n   <= !phase_nx;
        end
    end

    // read data is sampled at the edge ending the last cycle of each read phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 32'd0;
        end else if (last && !op_wr) begin
            if (state == LO) rdata[15:0] <= sram_dq_in;
            if (state == HI) rdata[31:16] <= sram_dq_in;
        end
    end
endmodule
